// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 execute-stage opcodes, ALUOp encodings and multiplier states
package legv8_pkg;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier retiring MUL_STEP bits of b per cycle
module seq_multiplier
  import legv8_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  mul_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_b_lsbs;
  logic [WIDTH-1:0] w_partial;

  assign w_b_lsbs  = WIDTH'(r_b[MUL_STEP-1:0]);
  assign w_partial = r_a * w_b_lsbs;

  // Always runs all STEPS iterations so latency never depends on operand values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc <= r_acc + w_partial;
          r_a   <= r_a << MUL_STEP;
          r_b   <= r_b >> MUL_STEP;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= DONE;
        end
        DONE: begin
          if (ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == BUSY);
  assign done    = (r_state == DONE);
  assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - LEGv8 EX stage: operand mux, ALU, branch adder and MUL stall control
module execute_stage
  import legv8_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignExtendImmediate,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic [10:0]      Opcode,
  input  logic             Branch,
  input  logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] BranchTarget,
  output logic             PCSrc,
  output logic             stall,
  output logic             mul_busy
);

  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_product;
  logic             w_busy;
  logic             w_done;
  logic             w_start;

  assign w_op_b  = ALUSrc ? SignExtendImmediate : ReadData2;
  assign w_start = hit && (ALUOp == ALUOP_RTYPE) && (Opcode == OP_MUL) && !w_busy && !w_done;

  always_comb begin
    w_alu = '0;
    case (ALUOp)
      ALUOP_ADD:   w_alu = ReadData1 + w_op_b;
      ALUOP_PASSB: w_alu = w_op_b;
      ALUOP_RTYPE: begin
        case (Opcode)
          OP_ADD:  w_alu = ReadData1 + w_op_b;
          OP_SUB:  w_alu = ReadData1 - w_op_b;
          OP_AND:  w_alu = ReadData1 & w_op_b;
          OP_ORR:  w_alu = ReadData1 | w_op_b;
          default: w_alu = '0;
        endcase
      end
      default: w_alu = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .a       (ReadData1),
    .b       (w_op_b),
    .ack     (hit),
    .busy    (w_busy),
    .done    (w_done),
    .product (w_product)
  );

  // Once DONE the product is held until the pipeline advances, whatever the inputs do.
  assign ALUResult    = w_done ? w_product : w_alu;
  assign Zero         = (ALUResult == '0);
  assign BranchTarget = PC + (SignExtendImmediate << 2);
  assign PCSrc        = Branch & Zero;
  assign stall        = w_start | w_busy;
  assign mul_busy     = w_busy | w_done;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage against an arithmetic reference model
module tb_execute_stage;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit;
  logic [63:0] rd1, rd2, imm, pc;
  logic        alusrc, branch;
  logic [1:0]  aluop;
  logic [10:0] opcode;
  logic [63:0] alu_result, branch_target;
  logic        zero, pcsrc, stall, mul_busy;

  typedef struct {
    logic [63:0] result;
    logic        zero;
    logic        pcsrc;
    logic [63:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  execute_stage #(.WIDTH(64), .MUL_STEP(1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hit                 (hit),
    .ReadData1           (rd1),
    .ReadData2           (rd2),
    .SignExtendImmediate (imm),
    .ALUSrc              (alusrc),
    .ALUOp               (aluop),
    .Opcode              (opcode),
    .Branch              (branch),
    .PC                  (pc),
    .ALUResult           (alu_result),
    .Zero                (zero),
    .BranchTarget        (branch_target),
    .PCSrc               (pcsrc),
    .stall               (stall),
    .mul_busy            (mul_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b_reg,
                                 input logic [63:0] im, input logic src, input logic [1:0] op,
                                 input logic [10:0] opc, input logic br, input logic [63:0] p);
    exp_t e;
    logic [63:0] b;
    logic [127:0] full;
    b = src ? im : b_reg;
    e.result = 64'd0;
    if (op == 2'd0) e.result = a + b;
    else if (op == 2'd1) e.result = b;
    else if (op == 2'd2) begin
      if (opc == OP_ADD) e.result = a + b;
      else if (opc == OP_SUB) e.result = a - b;
      else if (opc == OP_AND) e.result = a & b;
      else if (opc == OP_ORR) e.result = a | b;
      else if (opc == OP_MUL) begin
        full = {64'd0, a} * {64'd0, b};
        e.result = full[63:0];
      end
    end
    e.zero   = (e.result == 64'd0);
    e.pcsrc  = br && e.zero;
    e.target = p + im * 64'd4;
    return e;
  endfunction

  // Monitor: EX/MEM loads whenever a valid instruction is not stalled.
  always @(negedge clk) begin
    if (!rst && hit && !stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", alu_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("alu_result", alu_result, e.result);
        check("zero_pcsrc", {62'd0, zero, pcsrc}, {62'd0, e.zero, e.pcsrc});
        check("branch_target", branch_target, e.target);
      end
    end
  end

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic src, input logic [1:0] op, input logic [10:0] opc,
                       input logic br, input logic [63:0] p, input logic h);
    rd1 = a; rd2 = b; imm = im; alusrc = src; aluop = op; opcode = opc;
    branch = br; pc = p; hit = h;
    if (h) exp_q.push_back(model(a, b, im, src, op, opc, br, p));
  endtask

  task automatic wait_accept(output int stalls);
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!stall) begin
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL accept_timeout: got stall after %0d cycles, expected release", stalls);
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic src, input logic [1:0] op, input logic [10:0] opc,
                       input logic br, input logic [63:0] p, output int stalls);
    drive(a, b, im, src, op, opc, br, p, 1'b1);
    wait_accept(stalls);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    int st;
    logic [63:0] a, b;
    logic [1:0]  op;
    logic [10:0] opc;
    logic [10:0] non_mul [5];
    non_mul = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, 11'b11111000010};

    rst = 1'b1;
    drive(64'd0, 64'd0, 64'd0, 1'b0, 2'd0, 11'd0, 1'b0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_mul_busy", {63'd0, mul_busy}, 64'd0);
    check("reset_zero", {63'd0, zero}, 64'd1);
    @(posedge clk); #1;

    issue(64'd5, 64'd7, 64'd0, 1'b0, 2'd2, OP_ADD, 1'b0, 64'd0, st);
    check("add_stall_cycles", st, 64'd0);

    issue(64'h10, 64'h10, 64'd3, 1'b0, 2'd2, OP_SUB, 1'b1, 64'h100, st);
    check("sub_stall_cycles", st, 64'd0);

    issue(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 2'd2, OP_MUL, 1'b0, 64'h40, st);
    check("mul_stall_cycles", st, 64'd65);
    hit = 1'b0;
    @(negedge clk);
    check("mul_idle_after_hit", {63'd0, mul_busy}, 64'd0);
    @(posedge clk); #1;

    issue(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0, 2'd2, OP_MUL, 1'b1, 64'h80, st);
    check("mul_wrap_stall_cycles", st, 64'd65);

    drive(64'd0, 64'd9, 64'd0, 1'b0, 2'd2, OP_MUL, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("nohit_mul_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1;
    check("nohit_mul_busy", {63'd0, mul_busy}, 64'd0);

    drive(64'd11, 64'd13, 64'd0, 1'b0, 2'd2, OP_MUL, 1'b0, 64'd0, 1'b0);
    hit = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; hit = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mul_stall", {63'd0, stall}, 64'd0);
    check("rst_mid_mul_busy", {63'd0, mul_busy}, 64'd0);
    @(posedge clk); #1;
    issue(64'd1, 64'd1, 64'd0, 1'b0, 2'd2, OP_ADD, 1'b0, 64'd0, st);

    drive(64'd123456789, 64'd987654321, 64'd0, 1'b0, 2'd2, OP_MUL, 1'b0, 64'd0, 1'b1);
    @(posedge clk); #1 hit = 1'b0;
    for (int i = 0; i < 80 && stall; i++) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_hold_result", alu_result, 64'd121932631112635269);
      check("done_hold_stall_busy", {62'd0, stall, mul_busy}, 64'd1);
      @(posedge clk); #1;
    end
    hit = 1'b1;
    @(posedge clk); #1;
    drive(64'd7, 64'd0, 64'd6, 1'b1, 2'd2, OP_MUL, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    check("b2b_mul_starts", {63'd0, stall}, 64'd1);
    wait_accept(st);
    check("b2b_mul_stall_cycles", st + 1, 64'd65);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        hit = 1'b0;
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 2))
        0: begin a = 64'($urandom_range(0, 15)); b = 64'($urandom_range(0, 15)); end
        1: begin a = {$urandom, $urandom}; b = a; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      if ($urandom_range(0, 9) == 0) begin
        op = 2'd2; opc = OP_MUL;
      end else begin
        op = 2'($urandom_range(0, 3));
        opc = non_mul[$urandom_range(0, 4)];
      end
      issue(a, b, {{32{1'b0}}, $urandom}, 1'($urandom_range(0, 1)), op, opc,
            1'($urandom_range(0, 1)), {$urandom, $urandom}, st);
      check("rand_stall_cycles", st, (opc == OP_MUL && op == 2'd2) ? 64'd65 : 64'd0);
    end

    hit = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
